// File: rtl/logic_gate_pkg.sv
// Shared op encodings and widths for the logic gate unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package logic_gate_pkg;

    localparam int OP_W = 3;

    // Six bitwise ops plus two reserved codes that complete as illegal.
    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

endpackage

// File: rtl/logic_gate_if.sv
// Operand/result bus between a producer and the logic gate unit.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the input side (in_*) and the result side (out_*).
// Ports: a, b, op, in_valid -> unit; in_ready <- unit; out, red_out, out_valid,
//        err, op_count <- unit; out_ready -> unit.
interface logic_gate_if
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             red_out;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic [CNT_W-1:0] op_count;

    // Producer/consumer side (drives operands, accepts results).
    modport master (
        output a, b, op, in_valid, out_ready,
        input  in_ready, out, red_out, out_valid, err, op_count
    );

    // The logic gate unit itself.
    modport slave (
        input  a, b, op, in_valid, out_ready,
        output in_ready, out, red_out, out_valid, err, op_count
    );
endinterface

// File: rtl/logic_gate_core.sv
// Bitwise gate and matching reduction of the result; flags reserved op codes.
// Latency: combinational.
// Backpressure: none (pure function of a, b, op).
// Ports: a, b, op in; result, red, illegal out.
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             red,
    output logic             illegal
);

    always_comb begin
        result  = '0;
        red     = 1'b0;
        illegal = 1'b0;
        case (op_e'(op))
            OP_AND:  begin result = a & b;    red = &result; end
            OP_OR:   begin result = a | b;    red = |result; end
            OP_XOR:  begin result = a ^ b;    red = ^result; end
            OP_NAND: begin result = ~(a & b); red = &result; end
            OP_NOR:  begin result = ~(a | b); red = |result; end
            OP_XNOR: begin result = ~(a ^ b); red = ^result; end
            // Reserved codes produce zero result and zero reduction.
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit with valid/ready handshake, sticky error and op counter.
// Latency: 1 cycle from input fire to out_valid.
// Backpressure: single-entry output register; in_ready = !out_valid || out_ready.
// Ports: clk, rst_n (async active-low); bus (logic_gate_if.slave) carries
//        operands, result, handshake, err and op_count.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    logic_gate_if.slave  bus
);

    logic [WIDTH-1:0] core_result;
    logic             core_red;
    logic             core_illegal;
    logic             fire;

    logic_gate_core #(.WIDTH(WIDTH)) u_core (
        .a       (bus.a),
        .b       (bus.b),
        .op      (bus.op),
        .result  (core_result),
        .red     (core_red),
        .illegal (core_illegal)
    );

    // The output register frees up in the same cycle it is drained,
    // so a full stream runs without bubbles.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign fire         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= '0;
            bus.red_out   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
            bus.op_count  <= '0;
        end else begin
            if (fire) begin
                bus.out       <= core_result;
                bus.red_out   <= core_red;
                bus.out_valid <= 1'b1;
                bus.op_count  <= bus.op_count + CNT_W'(1);
                // Sticky: only reset clears it.
                if (core_illegal) begin
                    bus.err <= 1'b1;
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit: truth table, backpressure, streaming,
// illegal ops, counter wrap and asynchronous reset mid-transaction.
// Outputs are sampled 1 time unit after the rising edge.
module tb_logic_gate_unit;
    import logic_gate_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic_gate_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] tt_out [6];
    logic       tt_red [6];

    initial begin
        checks   = 0;
        failures = 0;
        bus.a = '0; bus.b = '0; bus.op = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;

        tt_out[0] = 8'hC0; tt_red[0] = 1'b0;
        tt_out[1] = 8'hFC; tt_red[1] = 1'b1;
        tt_out[2] = 8'h3C; tt_red[2] = 1'b0;
        tt_out[3] = 8'h3F; tt_red[3] = 1'b0;
        tt_out[4] = 8'h03; tt_red[4] = 1'b1;
        tt_out[5] = 8'hC3; tt_red[5] = 1'b0;

        // Reset state, with valid asserted to show nothing is accepted.
        bus.in_valid = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
        repeat (2) tick();
        chk("rst_out",       bus.out, 0);
        chk("rst_red",       bus.red_out, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_err",       bus.err, 0);
        chk("rst_op_count",  bus.op_count, 0);
        chk("rst_in_ready",  bus.in_ready, 1);
        do_reset();

        // Idle input is never captured.
        bus.a = 8'h12; bus.b = 8'h34; bus.in_valid = 1'b0;
        tick();
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_count",     bus.op_count, 0);

        // Truth table with F0/CC over the six legal ops.
        bus.a = 8'hF0; bus.b = 8'hCC; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.op = OP_W'(i);
            tick();
            chk($sformatf("tt_out_op%0d", i),   bus.out, tt_out[i]);
            chk($sformatf("tt_red_op%0d", i),   bus.red_out, tt_red[i]);
            chk($sformatf("tt_valid_op%0d", i), bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("tt_drain_valid", bus.out_valid, 0);
        chk("tt_count",       bus.op_count, 6);

        // Backpressure: held result, changing inputs must not be captured.
        do_reset();
        bus.out_ready = 1'b0;
        bus.a = 8'hFF; bus.b = 8'hFF; bus.op = OP_AND; bus.in_valid = 1'b1;
        tick();
        bus.a = 8'h00; bus.op = OP_OR;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out",      bus.out, 8'hFF);
            chk("bp_red",      bus.red_out, 1);
            chk("bp_valid",    bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            tick();
        end
        chk("bp_count_held", bus.op_count, 1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", bus.in_ready, 1);
        tick();
        chk("bp_drained_valid", bus.out_valid, 0);
        chk("bp_drained_ready", bus.in_ready, 1);
        chk("bp_count_final",   bus.op_count, 1);

        // Back-to-back stream of 10 XORs against 0F.
        do_reset();
        bus.b = 8'h0F; bus.op = OP_XOR; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.a = 8'(i * 17);
            tick();
            chk($sformatf("st_out%0d", i),   bus.out, 8'(i * 17) ^ 8'h0F);
            chk($sformatf("st_valid%0d", i), bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        chk("st_count", bus.op_count, 10);

        // Illegal ops complete, count, zero the result and set sticky err.
        do_reset();
        bus.a = 8'hFF; bus.b = 8'hFF; bus.op = 3'b111; bus.in_valid = 1'b1;
        tick();
        chk("ill_out",   bus.out, 0);
        chk("ill_red",   bus.red_out, 0);
        chk("ill_valid", bus.out_valid, 1);
        chk("ill_err",   bus.err, 1);
        chk("ill_count", bus.op_count, 1);
        bus.b = 8'h0F; bus.op = OP_OR;
        tick();
        chk("ill_next_out",   bus.out, 8'hFF);
        chk("ill_next_red",   bus.red_out, 1);
        chk("ill_next_err",   bus.err, 1);
        bus.op = 3'b110;
        tick();
        chk("ill6_out",   bus.out, 0);
        chk("ill6_err",   bus.err, 1);
        chk("ill6_count", bus.op_count, 3);
        bus.in_valid = 1'b0;
        repeat (2) tick();
        chk("ill_err_sticky", bus.err, 1);

        // Counter wrap: 17 fires into a 4-bit counter.
        do_reset();
        bus.op = OP_AND; bus.in_valid = 1'b1;
        repeat (17) tick();
        bus.in_valid = 1'b0;
        chk("wrap_count", bus.op_count, 1);

        // Reset asserted while a result is held under backpressure.
        do_reset();
        bus.out_ready = 1'b0;
        bus.a = 8'h5A; bus.b = 8'hFF; bus.op = 3'b111; bus.in_valid = 1'b1;
        tick();
        chk("mr_pre_valid", bus.out_valid, 1);
        chk("mr_pre_err",   bus.err, 1);
        bus.op = OP_XNOR;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out",      bus.out, 0);
        chk("mr_red",      bus.red_out, 0);
        chk("mr_valid",    bus.out_valid, 0);
        chk("mr_err",      bus.err, 0);
        chk("mr_count",    bus.op_count, 0);
        repeat (2) tick();
        chk("mr_no_fire_in_reset", bus.op_count, 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mr_in_ready", bus.in_ready, 1);
        // First edge after release accepts a fire.
        bus.a = 8'hF0; bus.b = 8'hCC; bus.op = OP_NOR; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("mr_first_out",   bus.out, 8'h03);
        chk("mr_first_count", bus.op_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
